// File: rtl/minione_seq.sv
// minione instruction sequencer: fetch/decode/exec from ROM, 3 cycles per instruction, issue on the 3rd.
// No backpressure: the datapath must accept dp_issue every time it strobes; start is ignored unless IDLE.
module minione_seq #(
    parameter int          PC_W    = 16,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    output logic            rom_rd,
    output logic [PC_W-1:0] rom_addr,
    input  logic [23:0]     rom_data,
    output logic [7:0]      dp_sel,
    output logic [7:0]      dp_op1,
    output logic [7:0]      dp_op2,
    output logic            dp_issue,
    input  logic            dp_lt,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [7:0] SEL_SKIP = 8'd9;
    localparam logic [7:0] SEL_JMP  = 8'd11;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [23:0]       ir;

    // The datapath fields come straight from ir; ir only changes at the end of
    // DECODE, so dp_* hold the previous EXEC value until the next EXEC begins.
    assign dp_sel   = ir[23:16];
    assign dp_op1   = ir[15:8];
    assign dp_op2   = ir[7:0];

    assign rom_addr = pc;
    assign rom_rd   = (state == FETCH);
    assign busy     = (state == FETCH) || (state == DECODE) || (state == EXEC);
    assign halted   = (state == HALTED);
    assign dp_issue = (state == EXEC) && ((dp_sel <= 8'd7) || (dp_sel == SEL_SKIP));

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH:  state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC: begin
                if (dp_sel == HALT_OP) begin
                    state_nxt = HALTED;
                end else begin
                    state_nxt = step ? IDLE : FETCH;
                    if (dp_sel == SEL_JMP)
                        pc_nxt = PC_W'({dp_op1, dp_op2});
                    else if (dp_sel == SEL_SKIP && dp_lt)
                        pc_nxt = pc + PC_W'(2);
                    else
                        pc_nxt = pc + PC_W'(1);
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == DECODE) ir <= rom_data;
        end
    end

endmodule

// File: tb/tb_minione_seq.sv
// Directed bench for minione_seq: ROM model, per-cycle trace of fetches and issues.
module tb_minione_seq;

    localparam int PC_W = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            step;
    logic            rom_rd;
    logic [PC_W-1:0] rom_addr;
    logic [23:0]     rom_data;
    logic [7:0]      dp_sel;
    logic [7:0]      dp_op1;
    logic [7:0]      dp_op2;
    logic            dp_issue;
    logic            dp_lt;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;

    logic [23:0] rom [0:65535];

    logic [15:0] fetch_q[$];
    logic [23:0] iss_q[$];
    int          iss_t[$];
    int          n_checks = 0;
    int          n_errors = 0;

    minione_seq #(.PC_W(PC_W), .HALT_OP(8'hFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .step     (step),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .dp_sel   (dp_sel),
        .dp_op1   (dp_op1),
        .dp_op2   (dp_op2),
        .dp_issue (dp_issue),
        .dp_lt    (dp_lt),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples n consecutive negedges, recording fetch addresses and issued words.
    task automatic trace(input int n);
        fetch_q.delete();
        iss_q.delete();
        iss_t.delete();
        for (int i = 0; i < n; i++) begin
            if (rom_rd) fetch_q.push_back(rom_addr);
            if (dp_issue) begin
                iss_q.push_back({dp_sel, dp_op1, dp_op2});
                iss_t.push_back(i);
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 8; a++) rom[a] = 24'h0;
        rom[16'hFFFE] = 24'h0;
        rom[16'hFFFF] = 24'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        step  = 1'b0;
        dp_lt = 1'b0;
        clear_rom();

        // Reset / idle
        @(negedge clk);
        do_reset();
        trace(4);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_rom_rd", rom_rd, 0);
        chk("rst_dp_sel", dp_sel, 0);
        chk("rst_no_issue", iss_q.size(), 0);
        chk("rst_no_fetch", fetch_q.size(), 0);

        // Straight-line run to HALT
        rom[0] = {8'd0, 8'd10, 8'd0};
        rom[1] = {8'd6, 8'd4, 8'd0};
        rom[2] = {8'd1, 8'd15, 8'd22};
        rom[3] = {8'hFF, 8'd0, 8'd0};
        pulse_start();
        trace(15);
        chk("run_issue_cnt", iss_q.size(), 3);
        if (iss_q.size() == 3) begin
            chk("run_iss0", iss_q[0], 24'h000A00);
            chk("run_iss1", iss_q[1], 24'h060400);
            chk("run_iss2", iss_q[2], 24'h010F16);
            chk("run_t0", iss_t[0], 2);
            chk("run_gap01", iss_t[1] - iss_t[0], 3);
            chk("run_gap12", iss_t[2] - iss_t[1], 3);
        end
        chk("run_fetch_cnt", fetch_q.size(), 4);
        chk("run_pc", pc, 3);
        chk("run_halted", halted, 1);
        chk("run_busy", busy, 0);
        chk("run_dp_hold", {dp_sel, dp_op1, dp_op2}, 24'hFF0000);
        start = 1'b1;
        trace(4);
        start = 1'b0;
        chk("halt_start_pc", pc, 3);
        chk("halt_start_halted", halted, 1);
        chk("halt_start_fetch", fetch_q.size(), 0);

        // Skip taken
        do_reset();
        clear_rom();
        rom[0] = {8'd9, 8'd6, 8'd0};
        rom[1] = {8'hFF, 8'd0, 8'd0};
        rom[2] = {8'hFF, 8'd0, 8'd0};
        dp_lt = 1'b1;
        pulse_start();
        trace(8);
        chk("skip1_fetch_cnt", fetch_q.size(), 2);
        if (fetch_q.size() == 2) chk("skip1_addr", fetch_q[1], 2);
        chk("skip1_issue_cnt", iss_q.size(), 1);
        chk("skip1_pc", pc, 2);

        // Skip not taken
        do_reset();
        dp_lt = 1'b0;
        pulse_start();
        trace(8);
        chk("skip0_fetch_cnt", fetch_q.size(), 2);
        if (fetch_q.size() == 2) chk("skip0_addr", fetch_q[1], 1);
        chk("skip0_pc", pc, 1);

        // Jump loop
        do_reset();
        clear_rom();
        rom[0] = {8'd11, 8'd0, 8'd3};
        rom[3] = {8'd11, 8'd0, 8'd3};
        pulse_start();
        trace(12);
        chk("jmp_fetch_cnt", fetch_q.size(), 4);
        if (fetch_q.size() == 4) begin
            chk("jmp_f0", fetch_q[0], 0);
            chk("jmp_f1", fetch_q[1], 3);
            chk("jmp_f3", fetch_q[3], 3);
        end
        chk("jmp_no_issue", iss_q.size(), 0);
        chk("jmp_busy", busy, 1);

        // Single step with pc wrap
        do_reset();
        clear_rom();
        step = 1'b1;
        rom[0]        = {8'd11, 8'hFF, 8'hFF};
        rom[16'hFFFF] = {8'd1, 8'd1, 8'd1};
        pulse_start();
        trace(5);
        chk("step_jmp_pc", pc, 16'hFFFF);
        chk("step_jmp_idle", busy, 0);
        pulse_start();
        trace(5);
        chk("step_wrap_issue_cnt", iss_q.size(), 1);
        if (iss_q.size() == 1) chk("step_wrap_iss", iss_q[0], 24'h010101);
        chk("step_wrap_pc", pc, 0);
        chk("step_wrap_idle", busy, 0);
        pulse_start();
        trace(6);
        chk("step_one_fetch", fetch_q.size(), 1);
        chk("step_one_pc", pc, 16'hFFFF);

        // Skip wrapping from 0xFFFE to 0
        rom[0]        = {8'd11, 8'hFF, 8'hFE};
        rom[16'hFFFE] = {8'd9, 8'd0, 8'd0};
        do_reset();
        pulse_start();
        trace(4);
        chk("skipwrap_pre_pc", pc, 16'hFFFE);
        dp_lt = 1'b1;
        pulse_start();
        trace(4);
        dp_lt = 1'b0;
        chk("skipwrap_pc", pc, 0);
        step = 1'b0;

        // Reset during DECODE
        do_reset();
        clear_rom();
        rom[0] = {8'd2, 8'd5, 8'd5};
        rom[1] = {8'hFF, 8'd0, 8'd0};
        pulse_start();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_pc", pc, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_issue", dp_issue, 0);
        chk("midrst_dp_sel", dp_sel, 0);
        trace(4);
        chk("midrst_quiet", iss_q.size(), 0);
        pulse_start();
        trace(8);
        chk("midrst_rerun_cnt", iss_q.size(), 1);
        if (iss_q.size() == 1) chk("midrst_rerun_iss", iss_q[0], 24'h020505);
        chk("midrst_halted", halted, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minione_seq.md
Name: minione_seq

Overview:
- Instruction sequencer for the minione datapath.
- Fetches 24-bit instruction words {sel, op1, op2} from a program ROM, addressed by its own PC.
- Presents each word to the datapath with a one-cycle issue strobe, then resolves control flow (skip, jump, halt) locally.
- Sits between program memory and the minione ALU/register block; replaces bench-driven sel/op1/op2 stimulus.

Parameters:
- PC_W, 16, width of program counter and ROM address.
- HALT_OP, 8'hFF, sel value that stops the sequencer.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin/resume execution from IDLE.
- step  input  1  single-step mode: pause in IDLE after each executed instruction.
- rom_rd  output  1  ROM read request.
- rom_addr  output  PC_W  ROM word address (= pc).
- rom_data  input  24  instruction {sel[23:16], op1[15:8], op2[7:0]}; valid exactly one cycle after rom_rd.
- dp_sel  output  8  function select to datapath.
- dp_op1  output  8  operand 1 / register index.
- dp_op2  output  8  operand 2.
- dp_issue  output  1  one-cycle strobe: datapath executes dp_* this cycle.
- dp_lt  input  1  datapath compare flag, ACC < R[dp_op1]; combinational, valid while dp_* are driven.
- pc  output  PC_W  current program counter.
- busy  output  1  high in FETCH, DECODE, EXEC.
- halted  output  1  high in HALTED.

Behaviour:
- Reset (rst_n low at clk edge):
  - state=IDLE, pc=0, ir=0.
  - dp_sel/op1/op2=0, dp_issue=0, rom_rd=0, busy=0, halted=0.
  - Applies mid-instruction too; any in-flight fetch is discarded and no issue follows.
- FSM states: IDLE, FETCH, DECODE, EXEC, HALTED.
- IDLE:
  - start=1 -> FETCH.
  - Otherwise hold. pc is unchanged.
- FETCH:
  - rom_rd=1, rom_addr=pc.
  - -> DECODE.
- DECODE:
  - ir <= rom_data.
  - -> EXEC.
- EXEC:
  - dp_sel/op1/op2 = ir fields.
  - dp_issue=1 iff ir.sel in {0..7, 9}.
  - Next pc:
    - sel 11 (JMP): pc <= {op1, op2} truncated/zero-extended to PC_W.
    - sel 9 (skip): pc <= pc+2 if dp_lt=1 in this cycle, else pc+1.
    - sel == HALT_OP: pc unchanged, -> HALTED.
    - All other sel (incl. unused 8, 10, 12..HALT_OP-1): pc+1. Unused codes are NOPs with no dp_issue.
  - Next state (non-halt): step=1 -> IDLE; else -> FETCH.
- HALTED:
  - halted=1, busy=0, start ignored.
  - Only reset exits.
- Timing:
  - Throughput is 3 cycles per instruction.
  - dp_issue occurs on the 3rd cycle after FETCH entry.
- pc arithmetic is modulo 2^PC_W: 0xFFFF+1 -> 0; skip at 0xFFFE -> 0, at 0xFFFF -> 1.
- dp_sel/op1/op2 hold their last EXEC value outside EXEC. dp_issue=0 outside EXEC.
- start while busy is ignored.
- step is sampled only in EXEC.
- JMP to own address is legal and loops forever.
- rom_rd is high only in FETCH. rom_addr equals pc at all times.

Test Plan:
- Reset/idle:
  - Hold rst_n=0 2 cycles, then release with start=0 -> pc=0, busy=0, dp_issue never asserts, rom_rd=0.
- Straight-line run:
  - ROM[0]={0,10,0}, [1]={6,4,0}, [2]={1,15,22}, [3]={HALT_OP,0,0}; pulse start.
  - dp_issue pulses 3 times, 3 cycles apart, with matching dp_* values.
  - Ends with pc=3, halted=1. A later start leaves state unchanged.
- Skip:
  - ROM[0]={9,6,0}, dp_lt=1 -> next fetch at addr 2.
  - Repeat with dp_lt=0 -> next fetch at addr 1.
- Jump/loop:
  - ROM[0]={11,0,3}, [3]={11,0,3} -> fetch addresses 0, 3, 3, 3…
  - dp_issue stays 0 throughout.
- Single-step and wrap:
  - step=1, pc preloaded via JMP to 0xFFFF, ROM[0xFFFF]={1,1,1}.
  - After its issue, FSM returns to IDLE with pc=0. The next start executes exactly one instruction.
- Reset mid-op:
  - Assert rst_n=0 during DECODE -> next cycle state IDLE, pc=0, no dp_issue.
  - ROM[0] re-executes after a new start.
